// File: rtl/i2c_burst_seq.sv
// Burst command sequencer in front of an I2C master: one cmd handshake, then a write or read burst.
// Optional read-data checker: define CHECK_EN to compare read bytes against the seed pattern.
module i2c_burst_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_rd_mode,
    input  logic              i_no_stop,
    input  logic [ADDR_W-1:0] i_dev_addr,
    input  logic [LEN_W-1:0]  i_len_in,
    input  logic [DATA_W-1:0] i_seed,
    output logic [3:0]        o_cmd,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LEN_W-1:0]  o_burst_len,
    output logic              o_cmd_vld,
    input  logic              i_cmd_ready,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_vld,
    output logic              o_wr_last,
    input  logic              i_wr_ready,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_vld,
    output logic              o_rd_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ERR_W-1:0]  o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_FSH  = 3'd4
    } state_t;

    localparam logic [LEN_W:0]  CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] PAT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] cmd_code(input logic rd, input logic ns);
        logic [3:0] code;
        case ({rd, ns})
            2'b00:   code = 4'd1;
            2'b01:   code = 4'd2;
            2'b10:   code = 4'd3;
            2'b11:   code = 4'd4;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    state_t              r_state;
    logic                r_rd_mode;
    logic [3:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic                r_cmd_vld;
    logic [DATA_W-1:0]   r_pat;
    logic [LEN_W:0]      r_cnt;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_vld;
    logic                r_wr_last;
    logic                r_rd_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_start_acc;
    logic                w_rd_fire;
    logic [LEN_W:0]      w_cnt_nxt;
    logic                w_at_end;
    logic                w_last_nxt;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_rd_fire   = (r_state == S_RD) && r_rd_ready && i_rd_vld;
    assign w_cnt_nxt   = r_cnt + CNT_ONE;
    // counters carry an extra bit so burst_len=all-ones runs 2^LEN_W beats without wrapping
    assign w_at_end    = (r_cnt == {1'b0, r_len});
    assign w_last_nxt  = (w_cnt_nxt == {1'b0, r_len});

    // burst sequencer FSM with all handshake outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd_mode  <= 1'b0;
            r_cmd      <= 4'd0;
            r_addr     <= {ADDR_W{1'b0}};
            r_len      <= {LEN_W{1'b0}};
            r_cmd_vld  <= 1'b0;
            r_pat      <= {DATA_W{1'b0}};
            r_cnt      <= {(LEN_W+1){1'b0}};
            r_wr_data  <= {DATA_W{1'b0}};
            r_wr_vld   <= 1'b0;
            r_wr_last  <= 1'b0;
            r_rd_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_rd_mode <= i_rd_mode;
                        r_cmd     <= cmd_code(i_rd_mode, i_no_stop);
                        r_addr    <= i_dev_addr;
                        r_len     <= i_len_in;
                        r_pat     <= i_seed;
                        r_cnt     <= {(LEN_W+1){1'b0}};
                        r_cmd_vld <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_CMD;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_CMD: begin
                    if (r_cmd_vld && i_cmd_ready) begin
                        r_cmd_vld <= 1'b0;
                        if (r_rd_mode) begin
                            r_rd_ready <= 1'b1;
                            r_state    <= S_RD;
                        end else begin
                            r_wr_vld  <= 1'b1;
                            r_wr_data <= r_pat;
                            r_pat     <= r_pat + PAT_ONE;
                            r_wr_last <= w_at_end;
                            r_state   <= S_WR;
                        end
                    end else begin
                        r_state <= S_CMD;
                    end
                end
                S_WR: begin
                    if (r_wr_vld && i_wr_ready) begin
                        if (r_wr_last) begin
                            r_wr_vld  <= 1'b0;
                            r_wr_last <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_FSH;
                        end else begin
                            r_cnt     <= w_cnt_nxt;
                            r_wr_data <= r_pat;
                            r_pat     <= r_pat + PAT_ONE;
                            r_wr_last <= w_last_nxt;
                        end
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_RD: begin
                    if (w_rd_fire) begin
                        if (w_at_end) begin
                            r_rd_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_FSH;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                            r_pat <= r_pat + PAT_ONE;
                        end
                    end else begin
                        r_state <= S_RD;
                    end
                end
                S_FSH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cmd_vld  <= 1'b0;
                    r_wr_vld   <= 1'b0;
                    r_wr_last  <= 1'b0;
                    r_rd_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHECK_EN
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_ONE;
    endfunction

    logic [ERR_W-1:0] r_err_cnt;
    logic             w_rd_bad;

    // r_pat tracks seed+k for the byte currently being accepted
    assign w_rd_bad = w_rd_fire && (i_rd_data != r_pat);

    // read mismatch counter, cleared by an accepted start and saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= {ERR_W{1'b0}};
        end else if (w_start_acc) begin
            r_err_cnt <= {ERR_W{1'b0}};
        end else if (w_rd_bad) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    logic w_unused_rd;

    assign w_unused_rd = ^i_rd_data;
    assign o_err_cnt   = {ERR_W{1'b0}};
`endif

    assign o_cmd       = r_cmd;
    assign o_addr      = r_addr;
    assign o_burst_len = r_len;
    assign o_cmd_vld   = r_cmd_vld;
    assign o_wr_data   = r_wr_data;
    assign o_wr_vld    = r_wr_vld;
    assign o_wr_last   = r_wr_last;
    assign o_rd_ready  = r_rd_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
